conv_sched: RTL

- Shares one fixed-latency float32-to-16-bit conversion pipeline (the conv core) between NREQ requesters, e.g. parallel SZ prediction lanes.
- Accepts at most one float per cycle, using a round-robin grant.
- Tags each issued operand with its requester ID and carries the tag alongside the core's pipeline.
- Returns each result, with its overflow flag, tagged with the ID of the requester that issued it.

---
 rtl/conv_sched_pkg.sv | 27 ++
 rtl/conv_sched_if.sv | 38 +++
 rtl/conv_sched_rr_arbiter.sv | 58 +++++
 rtl/conv_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared widths, default parameters and the tag type for conv_sched.
//   FP32_W / RES_W   : operand and result widths of the conversion core
//   NREQ_DEFAULT     : default requester count
//   LAT_DEFAULT      : default conversion core latency
//   IDW_MAX          : tag ID width wide enough for any legal NREQ (up to 16)
//   tag_t            : {valid, id} carried alongside the conversion pipeline
// Optional build feature (in conv_sched): CONV_SCHED_OVF_CNT_EN.

package conv_sched_pkg;

  localparam int unsigned FP32_W       = 32;
  localparam int unsigned RES_W        = 16;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned IDW_DEFAULT  = 2;
  localparam int unsigned LAT_DEFAULT  = 6;

  // Packages cannot be parameterised, so the tag ID is sized for the largest
  // legal NREQ and the low IDW bits are used.
  localparam int unsigned IDW_MAX = 4;

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/conv_sched_if.sv
// conv_sched_if: requester, conversion-core and response signals of conv_sched.
//   req_valid/req_data/req_ready        : requester side, one lane per requester
//   cv_valid/cv_data/cv_result/cv_overflow : shared conversion core
//   rsp_valid/rsp_id/rsp_result/rsp_overflow : tagged results
// Modports: slave = the scheduler, master = the environment around it.

interface conv_sched_if
  import conv_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned IDW  = IDW_DEFAULT
);

  logic [NREQ-1:0]        req_valid;
  logic [FP32_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ready;

  logic                   cv_valid;
  logic [FP32_W-1:0]      cv_data;
  logic [RES_W-1:0]       cv_result;
  logic                   cv_overflow;

  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [RES_W-1:0]       rsp_result;
  logic                   rsp_overflow;

  modport slave (
    input  req_valid, req_data, cv_result, cv_overflow,
    output req_ready, cv_valid, cv_data, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport master (
    output req_valid, req_data, cv_result, cv_overflow,
    input  req_ready, cv_valid, cv_data, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

endinterface

// File: rtl/conv_sched_rr_arbiter.sv
// conv_sched_rr_arbiter: NREQ-wide round-robin arbiter with its own pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   en         : 1 = grants allowed
//   req        : per-requester request
//   grant      : one-hot grant (combinational)
//   gnt_id     : encoded index of the granted requester
//   gnt_valid  : a grant is being given this cycle
// The search starts at the pointer and wraps; after a grant to i the pointer
// moves to i+1 so that requester gets lowest priority next time.

module conv_sched_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    if (en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr_q) + k) % NREQ;
        if (!gnt_valid && req[idx]) begin
          gnt_valid  = 1'b1;
          grant[idx] = 1'b1;
          gnt_id     = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt   = (32'(gnt_id) + 32'd1) % NREQ;
    ptr_d = gnt_valid ? IDW'(nxt) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// conv_sched: shares one fixed-latency float32 -> 16-bit conversion core between
// NREQ requesters. One operand per cycle is granted round-robin, issued to the
// core, and its requester ID travels down a tag pipeline matched to the core
// latency so each result comes back tagged with its owner.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 1 = new grants allowed; 0 = in-flight work drains
//   bus        : conv_sched_if.slave (requesters, conv core, responses)
//   busy       : an operation is in the issue register or the tag pipeline
// Optional (macro CONV_SCHED_OVF_CNT_EN):
//   ovf_clr    : synchronous clear of all overflow counters
//   ovf_cnt    : 16-bit saturating overflow counter per requester, packed
// Latency from grant cycle to rsp_valid is LAT+2 cycles.

module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned IDW  = IDW_DEFAULT,
  parameter int unsigned LAT  = LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  conv_sched_if.slave        bus,
`ifdef CONV_SCHED_OVF_CNT_EN
  input  logic               ovf_clr,
  output logic [CNT_W*NREQ-1:0] ovf_cnt,
`endif
  output logic               busy
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;

  conv_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (bus.req_valid),
    .grant     (grant),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign bus.req_ready = grant;

  // ---------------------------------------------------------------------------
  // Issue stage: operand and owner registered into the core
  // ---------------------------------------------------------------------------
  logic              cv_valid_q;
  logic [FP32_W-1:0] cv_data_q;
  logic [IDW-1:0]    issue_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_valid_q <= 1'b0;
      cv_data_q  <= '0;
      issue_id_q <= '0;
    end else begin
      cv_valid_q <= gnt_valid;
      if (gnt_valid) begin
        cv_data_q  <= bus.req_data[FP32_W*gnt_id +: FP32_W];
        issue_id_q <= gnt_id;
      end
    end
  end

  assign bus.cv_valid = cv_valid_q;
  assign bus.cv_data  = cv_data_q;

  // ---------------------------------------------------------------------------
  // Tag pipeline: the last stage lines up with cv_result/cv_overflow
  // ---------------------------------------------------------------------------
  tag_t tag_q [LAT];
  tag_t tag_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0].valid <= cv_valid_q;
      tag_q[0].id    <= IDW_MAX'(issue_id_q);
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_last = tag_q[LAT-1];

  // Upper tag ID bits are zero padding when IDW < IDW_MAX.
  logic unused_tag_id;
  assign unused_tag_id = ^tag_last.id;

  // ---------------------------------------------------------------------------
  // Response stage
  // ---------------------------------------------------------------------------
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [RES_W-1:0] rsp_result_q;
  logic             rsp_overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      rsp_valid_q <= tag_last.valid;
      rsp_id_q    <= tag_last.id[IDW-1:0];
      // Core outputs are only meaningful under a valid tag; otherwise hold.
      if (tag_last.valid) begin
        rsp_result_q   <= bus.cv_result;
        rsp_overflow_q <= bus.cv_overflow;
      end
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;

  // rsp_valid is deliberately excluded: busy covers only work still in flight.
  always_comb begin
    busy = cv_valid_q;
    for (int unsigned i = 0; i < LAT; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional per-requester overflow counters
  // ---------------------------------------------------------------------------
`ifdef CONV_SCHED_OVF_CNT_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (ovf_clr) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (rsp_valid_q && rsp_overflow_q) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (rsp_id_q == IDW'(i) && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ovf_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ovf_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule
